// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states, byte-lane width.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Unsigned variants exist only for loads; 011 and 11x are never legal.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (is_store && f3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed lane of a bus read word and sign- or zero-extends it.
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per request on a req/gnt/rvalid bus,
// stalling the pipeline until the access completes, is rejected, or times out.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            misaligned;
  logic [BE_W-1:0] be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] load_data;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (mem_rdata_i),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (load_data)
  );

  // Byte lanes are derived from funct3[1:0] so unsigned loads share the signed lanes.
  always_comb begin
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      F3_SH[1:0]: begin
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{wdata_i[15:0]}};
      end
      F3_SW[1:0]: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
    misaligned = ((funct3_i[1:0] == F3_LH[1:0]) && addr_i[0]) ||
                 ((funct3_i[1:0] == F3_LW[1:0]) && (addr_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    misalign_d = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && (memread_i || memwrite_i)) begin
          if (f3_illegal(funct3_i, memwrite_i)) begin
            err_d = 1'b1;
          end else if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            accept  = 1'b1;
            addr_d  = {addr_i[XLEN-1:2], 2'b00};
            off_d   = addr_i[1:0];
            be_d    = be_new;
            wdata_d = wdata_new;
            we_d    = memwrite_i;
            f3_d    = funct3_i;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid_i) begin
          rdata_d = load_data;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = (state_q == S_REQ) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = (state_q == S_DONE);
  assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) || accept;
  assign err_o       = err_q;
  assign misalign_o  = misalign_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a bus responder and a response monitor
// check the DUT independently of the directed stimulus sequence.
module tb_load_store_unit;

  localparam logic [2:0] KIND_DONE = 3'b100;
  localparam logic [2:0] KIND_ERR  = 3'b010;
  localparam logic [2:0] KIND_MIS  = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, memread_i, memwrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          gntDelay;
    int          rvDelay;
    logic [31:0] rdata;
  } bus_t;

  resp_t respQ[$];
  bus_t  busQ[$];
  int    checks = 0;
  int    failures = 0;
  int    respCount = 0;
  int    expCount = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .memread_i    (memread_i),
    .memwrite_i   (memwrite_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: unexpected event at time %0t", name, $time);
  endtask

  task automatic expectResp(input logic [2:0] kind, input logic [31:0] rdata);
    resp_t e;
    e.kind  = kind;
    e.rdata = rdata;
    respQ.push_back(e);
    expCount++;
  endtask

  task automatic expectBus(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                           input logic we, input int gntDelay, input int rvDelay, input logic [31:0] rdata);
    bus_t b;
    b.addr = addr; b.be = be; b.wdata = wdata; b.we = we;
    b.gntDelay = gntDelay; b.rvDelay = rvDelay; b.rdata = rdata;
    busQ.push_back(b);
  endtask

  // Called at posedge+1 in an idle cycle; returns at posedge+1 of the following cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic expStall);
    valid_i    = 1'b1;
    memread_i  = rd;
    memwrite_i = wr;
    funct3_i   = f3;
    addr_i     = addr;
    wdata_i    = wdata;
    #1;
    checkOutput("accept_stall", {31'd0, stall_o}, {31'd0, expStall});
    @(posedge clk); #1;
    valid_i    = 1'b0;
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
  endtask

  task automatic waitResponses();
    int n = 0;
    while (respCount < expCount && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (respCount < expCount) reportUnexpected("response_timeout");
  endtask

  // Monitor: every completion/reject pulse is matched against the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (done_o || err_o || misalign_o)) begin
        if (respQ.size() == 0) begin
          reportUnexpected("response");
        end else begin
          e = respQ.pop_front();
          checkOutput("resp_kind", {29'd0, done_o, err_o, misalign_o}, {29'd0, e.kind});
          checkOutput("resp_rdata", rdata_o, e.rdata);
        end
        respCount++;
      end
    end
  end

  // Bus responder: checks request fields every REQ cycle, grants and returns read data.
  initial begin
    bus_t        cur;
    logic        active = 1'b0;
    int          waitCnt = 0;
    int          rvCnt = 0;
    logic [31:0] rvData = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rvCnt > 0) begin
        rvCnt--;
        if (rvCnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rvData;
        end
      end
      if (mem_req_o) begin
        if (!active) begin
          if (busQ.size() == 0) begin
            reportUnexpected("mem_req_o");
          end else begin
            cur     = busQ.pop_front();
            active  = 1'b1;
            waitCnt = 0;
          end
        end
        if (active) begin
          checkOutput("bus_addr", mem_addr_o, cur.addr);
          checkOutput("bus_be", {28'd0, mem_be_o}, {28'd0, cur.be});
          checkOutput("bus_we", {31'd0, mem_we_o}, {31'd0, cur.we});
          if (cur.we) checkOutput("bus_wdata", mem_wdata_o, cur.wdata);
          if (waitCnt == cur.gntDelay) begin
            mem_gnt_i = 1'b1;
            active    = 1'b0;
            if (!cur.we) begin
              rvCnt  = cur.rvDelay;
              rvData = cur.rdata;
            end
          end else begin
            waitCnt++;
          end
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqCycles;
    reset = 1'b1; valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_flags", {26'd0, stall_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o}, 32'h0);
    checkOutput("reset_rdata", rdata_o, 32'h0);
    checkOutput("reset_be", {28'd0, mem_be_o}, 32'h0);

    // LW with minimum latency
    expectBus(32'h100, 4'b1111, 32'h0, 1'b0, 0, 1, 32'h8001_7F80);
    expectResp(KIND_DONE, 32'h8001_7F80);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    checkOutput("lw_stall_c1", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    checkOutput("lw_stall_c2", {31'd0, stall_o}, 32'd1);
    checkOutput("lw_req_c2", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    checkOutput("lw_done_c3", {31'd0, done_o}, 32'd1);
    checkOutput("lw_stall_c3", {31'd0, stall_o}, 32'd0);
    waitResponses();

    // LB vs LBU on the top byte lane
    expectBus(32'h100, 4'b1000, 32'h0, 1'b0, 0, 1, 32'h8012_3456);
    expectResp(KIND_DONE, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1);
    waitResponses();
    expectBus(32'h100, 4'b1000, 32'h0, 1'b0, 0, 1, 32'h8012_3456);
    expectResp(KIND_DONE, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1);
    waitResponses();

    // SH with delayed grant; rdata_o must stay untouched
    expectBus(32'h100, 4'b1100, 32'hABCD_ABCD, 1'b1, 3, 0, 32'h0);
    expectResp(KIND_DONE, 32'h0000_0080);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 1'b1);
    reqCycles = 0;
    while (mem_req_o && reqCycles < 20) begin
      reqCycles++;
      @(posedge clk); #1;
    end
    checkOutput("sh_req_cycles", reqCycles, 32'd4);
    checkOutput("sh_done_after_gnt", {31'd0, done_o}, 32'd1);
    waitResponses();

    // Misaligned and illegal requests: rejected without bus activity
    expectResp(KIND_MIS, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b0);
    checkOutput("mis_lw_req", {31'd0, mem_req_o}, 32'd0);
    waitResponses();
    expectResp(KIND_MIS, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h005, 32'h0, 1'b0);
    checkOutput("mis_lh_req", {31'd0, mem_req_o}, 32'd0);
    waitResponses();
    expectResp(KIND_ERR, 32'h0000_0080);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'h55, 1'b0);
    waitResponses();
    expectResp(KIND_ERR, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    waitResponses();

    // Bus never grants: abort after 8 REQ cycles
    expectBus(32'h200, 4'b1111, 32'h0, 1'b0, 1000, 1, 32'h0);
    expectResp(KIND_ERR, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1);
    reqCycles = 0;
    while (mem_req_o && reqCycles < 20) begin
      reqCycles++;
      @(posedge clk); #1;
    end
    checkOutput("timeout_req_cycles", reqCycles, 32'd8);
    checkOutput("timeout_err", {31'd0, err_o}, 32'd1);
    waitResponses();

    // Halfword loads, byte store, and a word store with memread also set
    expectBus(32'h104, 4'b1100, 32'h0, 1'b0, 0, 1, 32'h8765_1234);
    expectResp(KIND_DONE, 32'hFFFF_8765);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 1'b1);
    waitResponses();
    expectBus(32'h000, 4'b1100, 32'h0, 1'b0, 1, 2, 32'hBEEF_1234);
    expectResp(KIND_DONE, 32'h0000_BEEF);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 1'b1);
    waitResponses();
    expectBus(32'h000, 4'b0010, 32'hA5A5_A5A5, 1'b1, 0, 0, 32'h0);
    expectResp(KIND_DONE, 32'h0000_BEEF);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 1'b1);
    waitResponses();
    expectBus(32'h010, 4'b1111, 32'hDEAD_BEEF, 1'b1, 0, 0, 32'h0);
    expectResp(KIND_DONE, 32'h0000_BEEF);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 1'b1);
    waitResponses();

    // Reset while waiting for read data; the late rvalid must be ignored
    expectBus(32'h300, 4'b1111, 32'h0, 1'b0, 0, 3, 32'hCAFE_0000);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("wait_stall", {31'd0, stall_o}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_flags", {26'd0, stall_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o}, 32'h0);
    checkOutput("midreset_rdata", rdata_o, 32'h0);
    checkOutput("midreset_addr", mem_addr_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stale_done", {31'd0, done_o}, 32'd0);
      checkOutput("stale_rdata", rdata_o, 32'h0);
    end

    expectBus(32'h304, 4'b1111, 32'h0, 1'b0, 0, 1, 32'h1122_3344);
    expectResp(KIND_DONE, 32'h1122_3344);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 1'b1);
    waitResponses();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resp_queue_empty", respQ.size(), 32'd0);
    checkOutput("bus_queue_empty", busQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
